data_write_buffer: RTL and testbench

- Single-entry eviction write buffer between the L1 data cache and the L2 arbiter's data-side request port.
- Absorbs one dirty-line writeback so the L1 data cache can retire an eviction in one cycle. Serves L1 read misses from the buffer on a line match. Drains the buffered line to L2 when the data side is otherwise idle.
- Drives the arbiter's `L2data_rd_req`, `L2data_wr_req` and `L2data_address` inputs, and consumes `arb_data_resp`.

---
 rtl/data_write_buffer.sv | 130 +++++++++++++
 tb/tb_data_write_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_write_buffer.sv
// Single-entry eviction write buffer between the L1 data cache and the L2 arbiter.
// Absorbs one dirty line, serves matching reads from it, and drains it to L2 when idle.
module data_write_buffer (
  input  logic         clk,
  input  logic         reset,
  input  logic         dc_rd_req,
  input  logic         dc_wr_req,
  input  logic [15:0]  dc_address,
  input  logic [127:0] dc_wdata,
  output logic [127:0] dc_rdata,
  output logic         dc_resp,
  output logic         L2data_rd_req,
  output logic         L2data_wr_req,
  output logic [15:0]  L2data_address,
  output logic [127:0] L2_wdata,
  input  logic [127:0] L2_rdata,
  input  logic         arb_data_resp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           buf_valid_q, buf_valid_d;
  logic [11:0]    buf_line_q, buf_line_d;
  logic [127:0]   buf_data_q, buf_data_d;
  logic [11:0]    req_line_q, req_line_d;
  logic [127:0]   rdata_q, rdata_d;

  logic [11:0]    dc_line;
  logic           line_hit;
  logic           unused_offset;

  assign dc_line       = dc_address[15:4];
  assign line_hit      = buf_valid_q && (dc_line == buf_line_q);
  assign unused_offset = ^dc_address[3:0];

  assign dc_rdata = rdata_q;
  assign L2_wdata = buf_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      buf_valid_q <= 1'b0;
      buf_line_q  <= '0;
      buf_data_q  <= '0;
      req_line_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_line_q  <= buf_line_d;
      buf_data_q  <= buf_data_d;
      req_line_q  <= req_line_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    buf_valid_d    = buf_valid_q;
    buf_line_d     = buf_line_q;
    buf_data_d     = buf_data_q;
    req_line_d     = req_line_q;
    rdata_d        = rdata_q;
    dc_resp        = 1'b0;
    L2data_rd_req  = 1'b0;
    L2data_wr_req  = 1'b0;
    L2data_address = '0;

    case (state_q)
      S_IDLE: begin
        // Read misses go straight to L2: the buffer only ever holds a line L2 lacks.
        if (dc_rd_req) begin
          if (line_hit) begin
            rdata_d = buf_data_q;
            state_d = S_RESP;
          end else begin
            req_line_d = dc_line;
            state_d    = S_FETCH;
          end
        end else if (dc_wr_req) begin
          if (!buf_valid_q || line_hit) begin
            buf_line_d  = dc_line;
            buf_data_d  = dc_wdata;
            buf_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (buf_valid_q) begin
          state_d = S_DRAIN;
        end
      end

      S_FETCH: begin
        L2data_rd_req  = 1'b1;
        L2data_address = {req_line_q, 4'b0000};
        if (arb_data_resp) begin
          rdata_d = L2_rdata;
          state_d = S_RESP;
        end
      end

      S_DRAIN: begin
        L2data_wr_req  = 1'b1;
        L2data_address = {buf_line_q, 4'b0000};
        if (arb_data_resp) begin
          buf_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_RESP: begin
        dc_resp = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  a_l2_excl: assert property (@(posedge clk) disable iff (reset)
    !(L2data_rd_req && L2data_wr_req));

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed checks of data_write_buffer followed by randomized L1/arbiter traffic
// checked against a line-granular memory model.
module tb_data_write_buffer;
  logic         clk = 1'b0;
  logic         reset;
  logic         dc_rd_req, dc_wr_req;
  logic [15:0]  dc_address;
  logic [127:0] dc_wdata, dc_rdata;
  logic         dc_resp;
  logic         L2data_rd_req, L2data_wr_req;
  logic [15:0]  L2data_address;
  logic [127:0] L2_wdata, L2_rdata;
  logic         arb_data_resp;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [127:0] DA5 = {16{8'hA5}};
  localparam logic [127:0] D11 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [127:0] DB  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] DC  = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] DD  = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;

  data_write_buffer dut (
    .clk(clk), .reset(reset),
    .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req),
    .dc_address(dc_address), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .L2data_rd_req(L2data_rd_req), .L2data_wr_req(L2data_wr_req),
    .L2data_address(L2data_address), .L2_wdata(L2_wdata),
    .L2_rdata(L2_rdata), .arb_data_resp(arb_data_resp)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk1(tag, L2data_rd_req, 1'b0);
    chk1(tag, L2data_wr_req, 1'b0);
    chk1(tag, dc_resp, 1'b0);
    chk16(tag, L2data_address, 16'h0);
    chk128(tag, L2_wdata, '0);
    chk128(tag, dc_rdata, '0);
  endtask

  // Untouched L2 lines hold a recognisable pattern derived from the line address.
  function automatic logic [127:0] init_line(input logic [11:0] l);
    return {8{l, 4'h9}};
  endfunction

  logic [127:0] golden [logic [11:0]];
  logic [127:0] l2mem  [logic [11:0]];

  bit           pend, pend_wr, just_done, arb_act, arb_wr;
  logic [11:0]  pend_line, rline;
  logic [127:0] pend_data, exp_rd;
  logic [15:0]  arb_addr;
  int           wait_cyc, arb_dly;

  initial begin
    reset = 1'b1; dc_rd_req = 1'b0; dc_wr_req = 1'b0; dc_address = '0;
    dc_wdata = '0; L2_rdata = '0; arb_data_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1 all_zero("reset_state");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk1("post_reset_rd", L2data_rd_req, 1'b0);
    chk1("post_reset_wr", L2data_wr_req, 1'b0);

    // Write into empty buffer, then a read hit in the following IDLE cycle, then drain.
    dc_wr_req = 1'b1; dc_address = 16'h1234; dc_wdata = DA5;
    @(negedge clk);
    chk1("wr_resp", dc_resp, 1'b1);
    chk1("wr_no_l2", L2data_wr_req | L2data_rd_req, 1'b0);
    dc_wr_req = 1'b0; dc_rd_req = 1'b1; dc_address = 16'h123E;
    @(negedge clk);
    chk1("idle_no_resp", dc_resp, 1'b0);
    @(negedge clk);
    chk1("hit_resp", dc_resp, 1'b1);
    chk128("hit_data", dc_rdata, DA5);
    chk1("hit_no_l2", L2data_rd_req | L2data_wr_req, 1'b0);
    dc_rd_req = 1'b0;
    @(negedge clk);
    chk1("idle_before_drain", L2data_wr_req, 1'b0);
    @(negedge clk);
    chk1("drain_req", L2data_wr_req, 1'b1);
    chk1("drain_no_rd", L2data_rd_req, 1'b0);
    chk16("drain_addr", L2data_address, 16'h1230);
    chk128("drain_wdata", L2_wdata, DA5);
    @(negedge clk);
    chk1("drain_hold1", L2data_wr_req, 1'b1);
    @(negedge clk);
    chk1("drain_hold2", L2data_wr_req, 1'b1);
    chk16("drain_addr_hold", L2data_address, 16'h1230);
    arb_data_resp = 1'b1;
    @(negedge clk);
    arb_data_resp = 1'b0;
    chk1("drain_done", L2data_wr_req, 1'b0);
    @(negedge clk);
    chk1("no_redrain", L2data_wr_req, 1'b0);

    // Read miss serviced by L2 with the response on cycle 5.
    dc_rd_req = 1'b1; dc_address = 16'h4000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk1("miss_req", L2data_rd_req, 1'b1);
      chk16("miss_addr", L2data_address, 16'h4000);
      chk1("miss_no_resp", dc_resp, 1'b0);
      if (c == 5) begin
        L2_rdata = D11; arb_data_resp = 1'b1;
      end
    end
    @(negedge clk);
    arb_data_resp = 1'b0; L2_rdata = '0;
    chk1("miss_resp", dc_resp, 1'b1);
    chk128("miss_data", dc_rdata, D11);
    chk1("miss_req_drop", L2data_rd_req, 1'b0);
    dc_rd_req = 1'b0;
    @(negedge clk);
    chk128("rdata_hold", dc_rdata, D11);
    chk1("resp_one_cycle", dc_resp, 1'b0);

    // Write conflicting with an in-progress drain waits for it.
    dc_wr_req = 1'b1; dc_address = 16'h1230; dc_wdata = DB;
    @(negedge clk);
    chk1("e_wr_resp", dc_resp, 1'b1);
    dc_wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("e_drain", L2data_wr_req, 1'b1);
    chk16("e_drain_addr", L2data_address, 16'h1230);
    dc_wr_req = 1'b1; dc_address = 16'h567C; dc_wdata = DC;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk1("e_drain_hold", L2data_wr_req, 1'b1);
      chk16("e_drain_addr_hold", L2data_address, 16'h1230);
      chk128("e_drain_wdata", L2_wdata, DB);
      chk1("e_wait_no_resp", dc_resp, 1'b0);
    end
    arb_data_resp = 1'b1;
    @(negedge clk);
    arb_data_resp = 1'b0;
    chk1("e_drain_done", L2data_wr_req, 1'b0);
    chk1("e_accept_cycle", dc_resp, 1'b0);
    @(negedge clk);
    chk1("e_accept_resp", dc_resp, 1'b1);
    dc_wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("e_drain2", L2data_wr_req, 1'b1);
    chk16("e_drain2_addr", L2data_address, 16'h5670);
    chk128("e_drain2_wdata", L2_wdata, DC);
    arb_data_resp = 1'b1;
    @(negedge clk);
    arb_data_resp = 1'b0;
    chk1("e_drain2_done", L2data_wr_req, 1'b0);

    // Reset asserted mid-FETCH with a dirty line buffered.
    dc_wr_req = 1'b1; dc_address = 16'h7770; dc_wdata = DD;
    @(negedge clk);
    chk1("f_wr_resp", dc_resp, 1'b1);
    dc_wr_req = 1'b0; dc_rd_req = 1'b1; dc_address = 16'h8880;
    @(negedge clk);
    @(negedge clk);
    chk1("f_fetch", L2data_rd_req, 1'b1);
    chk16("f_fetch_addr", L2data_address, 16'h8880);
    chk128("f_buffered", L2_wdata, DD);
    #2 reset = 1'b1; arb_data_resp = 1'b1; L2_rdata = DA5;
    #1 all_zero("rst_async");
    @(negedge clk);
    all_zero("rst_held");
    reset = 1'b0; arb_data_resp = 1'b0; dc_rd_req = 1'b0; L2_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("f_dirty_lost", L2data_wr_req, 1'b0);
      chk1("f_no_fetch", L2data_rd_req, 1'b0);
    end

    // Randomized traffic against the memory model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    golden.delete(); l2mem.delete();
    pend = 0; arb_act = 0; wait_cyc = 0; arb_dly = 0; arb_wr = 0; arb_addr = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      chk1("l2_excl", L2data_rd_req & L2data_wr_req, 1'b0);
      if (dc_resp) chk1("resp_solicited", pend, 1'b1);

      just_done = 0;
      if (pend && dc_resp) begin
        if (pend_wr) golden[pend_line] = pend_data;
        else begin
          exp_rd = golden.exists(pend_line) ? golden[pend_line] : init_line(pend_line);
          chk128("rd_data", dc_rdata, exp_rd);
        end
        pend = 0; dc_rd_req = 1'b0; dc_wr_req = 1'b0; just_done = 1;
      end else if (pend) begin
        wait_cyc++;
        if (wait_cyc > 100) begin
          chk1("resp_timeout", dc_resp, 1'b1);
          pend = 0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
        end
      end
      if (!pend && !just_done && $urandom_range(0, 2) == 0) begin
        rline      = 12'h111 * 12'($urandom_range(0, 5));
        pend       = 1; wait_cyc = 0;
        pend_wr    = ($urandom_range(0, 1) == 1);
        pend_line  = rline;
        pend_data  = {$urandom, $urandom, $urandom, $urandom};
        dc_address = {rline, 4'($urandom)};
        dc_wdata   = pend_data;
        dc_wr_req  = pend_wr;
        dc_rd_req  = !pend_wr;
      end

      arb_data_resp = 1'b0;
      L2_rdata      = {$urandom, $urandom, $urandom, $urandom};
      if (L2data_rd_req || L2data_wr_req) begin
        if (!arb_act) begin
          arb_act = 1; arb_addr = L2data_address; arb_wr = L2data_wr_req;
          arb_dly = $urandom_range(0, 4);
        end else begin
          chk16("l2_addr_stable", L2data_address, arb_addr);
          chk1("l2_kind_stable", L2data_wr_req, arb_wr);
        end
        chk16("l2_addr_aligned", {12'h0, L2data_address[3:0]}, 16'h0);
        if (arb_dly == 0) begin
          arb_data_resp = 1'b1; arb_act = 0;
          rline = L2data_address[15:4];
          if (L2data_wr_req) begin
            chk1("drain_known", golden.exists(rline) ? 1'b1 : 1'b0, 1'b1);
            if (golden.exists(rline)) chk128("drain_data", L2_wdata, golden[rline]);
            l2mem[rline] = L2_wdata;
          end else begin
            L2_rdata = l2mem.exists(rline) ? l2mem[rline] : init_line(rline);
          end
        end else begin
          arb_dly--;
        end
      end else begin
        if (arb_act) chk1("l2_req_held", L2data_rd_req | L2data_wr_req, 1'b1);
        arb_act = 0;
        arb_data_resp = ($urandom_range(0, 7) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
